// File: rtl/data_mem_stage_pkg.sv
// Shared types and limits for the data memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned LAT_MAX = 15;
  localparam int unsigned CNT_W   = 4;

endpackage

// File: rtl/data_mem_stage_if.sv
// Pipeline-facing bus of the data memory stage: gated enables, decoded
// requests, address/data in, and load result plus status out.
interface data_mem_stage_if #(
  parameter int unsigned DATA_W = 32
);

  logic              MemReadReq;
  logic              MemWriteReq;
  logic              MemRead;
  logic              MemWrite;
  logic [31:0]       Address;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              Stall;
  logic              MemDone;
  logic              AlignErr;

  modport master (
    output MemReadReq, MemWriteReq, MemRead, MemWrite, Address, WriteData,
    input  ReadData, Stall, MemDone, AlignErr
  );

  modport slave (
    input  MemReadReq, MemWriteReq, MemRead, MemWrite, Address, WriteData,
    output ReadData, Stall, MemDone, AlignErr
  );

endinterface

// File: rtl/data_mem_stage_ram.sv
// Single-port synchronous word RAM with a registered (one-cycle) read.
module data_ram
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write on enable; read port always returns the addressed word one cycle later.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_stage.sv
// Memory-access stage: qualifies gated enables with the decoded request,
// performs fixed-latency word accesses to an internal RAM, stalls while busy
// and flags misaligned requests without touching memory.
module data_mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  data_mem_stage_if.slave bus
);

  if (LATENCY < 1 || LATENCY > LAT_MAX) begin : gLatCheck
    $error("data_mem_stage: LATENCY must be in 1..LAT_MAX");
  end

  state_t            state;
  state_t            nextState;
  logic [CNT_W-1:0]  cnt;
  logic              opWrite;
  logic [ADDR_W-1:0] wordAddr;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] readDataQ;

  logic              wr;
  logic              rd;
  logic              req;
  logic              aligned;
  logic              start;
  logic              lastBusy;

  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramRdata;

  // Request qualification: a write wins over a simultaneous read.
  always_comb begin
    wr       = bus.MemWriteReq & bus.MemWrite;
    rd       = bus.MemReadReq & bus.MemRead & ~wr;
    req      = wr | rd;
    aligned  = (bus.Address[1:0] == 2'b00);
    start    = (state == IDLE) & req & aligned;
    lastBusy = (state == BUSY) & (cnt == '0);
  end

  // The RAM is addressed straight from the bus in IDLE so the registered read
  // is already valid during the first BUSY cycle, even with LATENCY=1.
  always_comb begin
    ramAddr = (state == IDLE) ? bus.Address[ADDR_W+1:2] : wordAddr;
    ramWe   = lastBusy & opWrite;
  end

  data_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) uRam (
    .clk   (clk),
    .we    (ramWe),
    .addr  (ramAddr),
    .wdata (wdataQ),
    .rdata (ramRdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (start) nextState = BUSY;
      BUSY: if (cnt == '0) nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Status outputs.
  always_comb begin
    bus.Stall    = start | (state == BUSY);
    bus.MemDone  = (state == DONE);
    bus.AlignErr = (state == IDLE) & req & ~aligned;
  end

  // Operation latches and latency counter; inputs are only sampled on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      opWrite  <= 1'b0;
      wordAddr <= '0;
      wdataQ   <= '0;
    end else if (start) begin
      cnt      <= CNT_W'(LATENCY - 1);
      opWrite  <= wr;
      wordAddr <= bus.Address[ADDR_W+1:2];
      wdataQ   <= bus.WriteData;
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Load result register; only a completing read updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readDataQ <= '0;
    end else if (lastBusy && !opWrite) begin
      readDataQ <= ramRdata;
    end
  end

  assign bus.ReadData = readDataQ;

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: a transaction-level model checked
// every cycle, plus directed operations with literal expectations.
module tb_data_mem_stage;

  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  data_mem_stage_if #(.DATA_W(32)) bus ();

  data_mem_stage #(
    .ADDR_W  (AW),
    .DATA_W  (32),
    .LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted request occupies LATENCY+1 stalled
  // cycles, completes in the following cycle, and only then touches memory.
  logic [31:0] mMem [2**AW];
  bit          mKnown [2**AW];
  logic [31:0] mRd;
  bit          mRdKnown;
  int          mPhase = -1;
  bit          mOpWr;
  logic [AW-1:0] mWord;
  logic [31:0] mData;

  initial begin : compareProc
    logic eStall, eDone, eAlign, wr, rd, req, al;
    forever begin
      @(negedge clk);
      eStall = 1'b0;
      eDone  = 1'b0;
      eAlign = 1'b0;
      if (!rst_n) begin
        mPhase   = -1;
        mRd      = '0;
        mRdKnown = 1'b1;
      end else if (mPhase < 0) begin
        wr  = bus.MemWriteReq & bus.MemWrite;
        rd  = bus.MemReadReq & bus.MemRead & ~wr;
        req = wr | rd;
        al  = (bus.Address[1:0] == 2'b00);
        eStall = req & al;
        eAlign = req & ~al;
        if (req && al) begin
          mOpWr  = wr;
          mWord  = bus.Address[AW+1:2];
          mData  = bus.WriteData;
          mPhase = 1;
        end
      end else if (mPhase <= int'(LAT)) begin
        eStall = 1'b1;
        mPhase++;
      end else begin
        eDone = 1'b1;
        if (mOpWr) begin
          mMem[mWord]   = mData;
          mKnown[mWord] = 1'b1;
        end else begin
          mRd      = mMem[mWord];
          mRdKnown = mKnown[mWord];
        end
        mPhase = -1;
      end
      check("model.Stall",    32'(bus.Stall),    32'(eStall));
      check("model.MemDone",  32'(bus.MemDone),  32'(eDone));
      check("model.AlignErr", 32'(bus.AlignErr), 32'(eAlign));
      if (mRdKnown) check("model.ReadData", bus.ReadData, mRd);
    end
  end

  task automatic drive(input logic rq, input logic wq, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    bus.MemReadReq  = rq;
    bus.MemWriteReq = wq;
    bus.MemRead     = r;
    bus.MemWrite    = w;
    bus.Address     = a;
    bus.WriteData   = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Present one request for a single cycle, then watch (bounded) for completion.
  task automatic runOp(input string name, input logic rq, input logic wq, input logic r,
                       input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int expDoneAt, input int expStalls, input logic expAlign);
    int doneAt = -1;
    int stalls = 0;
    @(posedge clk);
    #2 drive(rq, wq, r, w, a, d);
    @(negedge clk);
    check({name, ".alignErr"}, 32'(bus.AlignErr), 32'(expAlign));
    if (bus.Stall) stalls++;
    @(posedge clk);
    #2 idle();
    for (int k = 1; k <= int'(LAT) + 4; k++) begin
      @(negedge clk);
      if (bus.Stall) stalls++;
      if (bus.MemDone) begin
        doneAt = k;
        break;
      end
    end
    check({name, ".doneAt"}, doneAt, expDoneAt);
    check({name, ".stalls"}, stalls, expStalls);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog expired");
  end

  initial begin : directed
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset.Stall",    32'(bus.Stall),    32'h0);
    check("reset.MemDone",  32'(bus.MemDone),  32'h0);
    check("reset.AlignErr", 32'(bus.AlignErr), 32'h0);
    check("reset.ReadData", bus.ReadData,      32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Store then load.
    runOp("store10", 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 3, 1'b0);
    check("store10.ReadData", bus.ReadData, 32'h0);
    runOp("load10", 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3, 3, 1'b0);
    check("load10.ReadData", bus.ReadData, 32'hDEADBEEF);

    // Suppressed store and suppressed load.
    runOp("supStore", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h12345678, -1, 0, 1'b0);
    runOp("supLoad", 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, -1, 0, 1'b0);
    runOp("reload10", 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3, 3, 1'b0);
    check("reload10.ReadData", bus.ReadData, 32'hDEADBEEF);

    // Misaligned load and store.
    runOp("misLoad", 1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0, -1, 0, 1'b1);
    check("misLoad.ReadData", bus.ReadData, 32'hDEADBEEF);
    runOp("misStore", 1'b0, 1'b1, 1'b0, 1'b1, 32'h22, 32'hCAFEF00D, -1, 0, 1'b1);

    // Simultaneous read and write: the write wins.
    runOp("both20", 1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 3, 3, 1'b0);
    check("both20.ReadData", bus.ReadData, 32'hDEADBEEF);
    runOp("load20", 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 3, 3, 1'b0);
    check("load20.ReadData", bus.ReadData, 32'hA5A5A5A5);

    // Reset during BUSY aborts a pending write.
    runOp("store24", 1'b0, 1'b1, 1'b0, 1'b1, 32'h24, 32'h5A5A0024, 3, 3, 1'b0);
    @(posedge clk);
    #2 drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h24, 32'h0BADF00D);
    @(posedge clk);
    #2 idle();
    @(negedge clk);
    check("rstMid.busyStall", 32'(bus.Stall), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rstMid.Stall",    32'(bus.Stall),    32'h0);
    check("rstMid.MemDone",  32'(bus.MemDone),  32'h0);
    check("rstMid.AlignErr", 32'(bus.AlignErr), 32'h0);
    check("rstMid.ReadData", bus.ReadData,      32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    runOp("load24", 1'b1, 1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 3, 3, 1'b0);
    check("load24.ReadData", bus.ReadData, 32'h5A5A0024);

    // Address wrap-around modulo the RAM size.
    runOp("store400", 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'h11111111, 3, 3, 1'b0);
    runOp("load000", 1'b1, 1'b0, 1'b1, 1'b0, 32'h000, 32'h0, 3, 3, 1'b0);
    check("load000.ReadData", bus.ReadData, 32'h11111111);

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
